// File: rtl/ui_button_conditioner.sv
// Multi-channel front-panel button conditioner: synchroniser, debounce, press/release
// pulses and a Step stream with hold-to-auto-repeat for menu value editing.
module ui_button_conditioner #(
  parameter int N_BTN        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] Button,
  input  logic             Enable,
  output logic [N_BTN-1:0] State,
  output logic [N_BTN-1:0] Press,
  output logic [N_BTN-1:0] Release,
  output logic [N_BTN-1:0] Step,
  output logic             Any
);

  typedef enum logic [1:0] {
    IDLE,
    HELD_WAIT,
    REPEATING
  } btn_fsm_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = (REPEAT_RATE > 0) ? CNT_W'(REPEAT_RATE - 1) : '0;

  logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
  logic [N_BTN-1:0]                  sync_btn;

  // NOTE: every flop, synchroniser included, is cleared by reset so a button held
  // through reset deassert is seen as a fresh edge rather than inherited state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Button};
    end
  end

  assign sync_btn = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             level_q, level_d;
    btn_fsm_e         fsm_q, fsm_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             step_q, step_d;
    logic             rise, fall;

    // NOTE: defaults first in every combinational block, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
      deb_cnt_d = '0;
      level_d   = level_q;
      if (sync_btn[i] != level_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          level_d = ~level_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // A falling level wins over any repeat tick due in the same cycle.
    always_comb begin
      fsm_d     = fsm_q;
      rep_cnt_d = rep_cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      step_d    = 1'b0;
      if (fall) begin
        fsm_d     = IDLE;
        rep_cnt_d = '0;
        release_d = 1'b1;
      end else begin
        unique case (fsm_q)
          IDLE: begin
            if (rise) begin
              press_d   = 1'b1;
              step_d    = 1'b1;
              rep_cnt_d = '0;
              fsm_d     = HELD_WAIT;
            end
          end
          HELD_WAIT: begin
            if (REPEAT_RATE == 0) begin
              if (rep_cnt_q != '1) rep_cnt_d = rep_cnt_q + 1'b1;
            end else if (rep_cnt_q == DELAY_LAST) begin
              step_d    = 1'b1;
              rep_cnt_d = '0;
              fsm_d     = REPEATING;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          REPEATING: begin
            if (rep_cnt_q == RATE_LAST) begin
              step_d    = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          default: fsm_d = IDLE;
        endcase
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        deb_cnt_q <= '0;
        rep_cnt_q <= '0;
        level_q   <= 1'b0;
        fsm_q     <= IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        step_q    <= 1'b0;
      end else begin
        deb_cnt_q <= deb_cnt_d;
        rep_cnt_q <= rep_cnt_d;
        level_q   <= level_d;
        fsm_q     <= fsm_d;
        // Enable only masks the pulses; the FSM keeps its cadence underneath.
        press_q   <= press_d & Enable;
        release_q <= release_d & Enable;
        step_q    <= step_d & Enable;
      end
    end

    assign State[i]   = level_q;
    assign Press[i]   = press_q;
    assign Release[i] = release_q;
    assign Step[i]    = step_q;
  end

  assign Any = |State;

endmodule
